// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: PC width, 2-bit counter encodings, reset PC.
package pipeline_pkg;

    // Word-address width of every PC in the pipeline (byte address [31:2]).
    localparam int unsigned PC_W = 30;

    // 2-bit direction counter encodings.
    typedef enum logic [1:0] {
        SNT = 2'b00,  // strongly not-taken
        WNT = 2'b01,  // weakly not-taken
        WT  = 2'b10,  // weakly taken
        ST  = 2'b11   // strongly taken
    } ctr_e;

    // Reset PC (byte address 0x00003034).
    localparam logic [PC_W-1:0] RESET_PC = 30'h0C0D;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating up/down counter step used on the BTB training path.
// Ports:
//   ctr        current counter value
//   inc        1 = step toward ST, 0 = step toward SNT
//   ctr_next_c stepped value (combinational)
module bp_sat_counter (
    input  logic [1:0] ctr,
    input  logic       inc,
    output logic [1:0] ctr_next_c
);

    import pipeline_pkg::*;

    // Saturating step: hold at ST on increment, at SNT on decrement.
    always_comb begin
        ctr_next_c = ctr;
        if (inc) begin
            if (ctr != ST) ctr_next_c = ctr + 2'd1;
        end else begin
            if (ctr != SNT) ctr_next_c = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational on fetch_pc; training is synchronous from EX.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   fetch_pc        current PC (word address)
//   predict_pc      next-PC guess (combinational)
//   predict_taken   BTB hit and counter MSB set (combinational)
//   upd_valid/pc/taken/target  branch resolution from EX
//   stall           pipeline bubble; only gates hit counting
//   hit_cnt         saturating count of non-stalled lookup hits
//   upd_cnt         saturating count of updates that changed the table
module branch_predictor #(
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned PC_W     = pipeline_pkg::PC_W,
    parameter logic [1:0]  CTR_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] fetch_pc,
    output logic [PC_W-1:0] predict_pc,
    output logic            predict_taken,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            stall,
    output logic [15:0]     hit_cnt,
    output logic [15:0]     upd_cnt
);

    import pipeline_pkg::*;

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = PC_W - IDX_W;

    // Valid bits kept apart from the arrays so reset clears them in one cycle.
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit_c;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit_c;
    logic [1:0]       u_ctr_c;
    logic [1:0]       ctr_next_c;
    logic             u_change_c;

    assign f_idx = fetch_pc[IDX_W-1:0];
    assign f_tag = fetch_pc[PC_W-1:IDX_W];
    assign u_idx = upd_pc[IDX_W-1:0];
    assign u_tag = upd_pc[PC_W-1:IDX_W];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        f_hit_c       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        predict_taken = f_hit_c && ctr_q[f_idx][1];
        predict_pc    = predict_taken ? target_q[f_idx] : fetch_pc + PC_W'(1);
    end

    // Training-side read of the entry addressed by the resolved branch.
    always_comb begin
        u_hit_c = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_ctr_c = ctr_q[u_idx];
    end

    bp_sat_counter u_ctr (
        .ctr        (u_ctr_c),
        .inc        (upd_taken),
        .ctr_next_c (ctr_next_c)
    );

    // Table changes on an allocation, or on a hit that moves the counter or retargets.
    always_comb begin
        u_change_c = 1'b0;
        if (upd_valid) begin
            if (u_hit_c) begin
                u_change_c = (ctr_next_c != u_ctr_c) ||
                             (upd_taken && (target_q[u_idx] != upd_target));
            end else begin
                u_change_c = upd_taken;
            end
        end
    end

    // Valid bits and counters: cleared by reset, trained otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            if (u_hit_c) begin
                ctr_q[u_idx] <= ctr_next_c;
            end else if (upd_taken) begin
                valid_q[u_idx] <= 1'b1;
                ctr_q[u_idx]   <= WT;
            end
        end
    end

    // Tag/target storage is not reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            target_q[u_idx] <= upd_target;
            if (!u_hit_c) tag_q[u_idx] <= u_tag;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= '0;
            upd_cnt <= '0;
        end else begin
            if (f_hit_c && !stall && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
            if (u_change_c && (upd_cnt != 16'hFFFF))      upd_cnt <= upd_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven bench for branch_predictor with an expected-value scoreboard.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [29:0] fetch_pc;
    logic [29:0] predict_pc;
    logic        predict_taken;
    logic        upd_valid;
    logic [29:0] upd_pc;
    logic        upd_taken;
    logic [29:0] upd_target;
    logic        stall;
    logic [15:0] hit_cnt;
    logic [15:0] upd_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .predict_pc    (predict_pc),
        .predict_taken (predict_taken),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .stall         (stall),
        .hit_cnt       (hit_cnt),
        .upd_cnt       (upd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [29:0] fetch;
        logic        uv;
        logic [29:0] upc;
        logic        ut;
        logic [29:0] utgt;
        logic        stall;
        logic [29:0] epc;
        logic        etak;
        logic [15:0] ehit;
        logic [15:0] eupd;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic add(input logic r, input logic [29:0] f, input logic uv,
                       input logic [29:0] upc, input logic ut, input logic [29:0] utgt,
                       input logic st, input logic [29:0] epc, input logic etak,
                       input logic [15:0] ehit, input logic [15:0] eupd);
        vec_t v;
        v.rst = r; v.fetch = f; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.stall = st; v.epc = epc; v.etak = etak; v.ehit = ehit; v.eupd = eupd;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge, then compare the combinational outputs
    // and the counters (which reflect earlier edges) before the next rising edge.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst = v.rst; fetch_pc = v.fetch; upd_valid = v.uv; upd_pc = v.upc;
        upd_taken = v.ut; upd_target = v.utgt; stall = v.stall;
        sb.push_back(v);
        #2;
        if (sb.size() == 0) begin
            check("scoreboard_empty", idx, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("predict_pc",    idx, 32'(predict_pc),    32'(e.epc));
            check("predict_taken", idx, 32'(predict_taken), 32'(e.etak));
            check("hit_cnt",       idx, 32'(hit_cnt),       32'(e.ehit));
            check("upd_cnt",       idx, 32'(upd_cnt),       32'(e.eupd));
        end
    endtask

    initial begin
        // rst fetch uv upc ut utgt stall | pc taken hit upd
        add(0, 30'h0C0D, 0, 30'h0,    0, 30'h0,    0, 30'h0C0E, 0, 0, 0); // reset state
        add(0, 30'h0C0D, 1, 30'h0C10, 1, 30'h0C00, 0, 30'h0C0E, 0, 0, 0); // allocate
        add(0, 30'h0C10, 0, 30'h0,    0, 30'h0,    0, 30'h0C00, 1, 0, 1); // hit, WT
        add(0, 30'h0C10, 1, 30'h0C10, 0, 30'h0,    0, 30'h0C00, 1, 1, 1); // same-cycle NT: old
        add(0, 30'h0C10, 1, 30'h0C10, 0, 30'h0,    0, 30'h0C11, 0, 2, 2); // ctr 01
        add(0, 30'h0C10, 1, 30'h0C10, 0, 30'h0,    0, 30'h0C11, 0, 3, 3); // ctr 00
        add(0, 30'h0C10, 0, 30'h0,    0, 30'h0,    1, 30'h0C11, 0, 4, 3); // 00 saturated; stall
        add(0, 30'h0C10, 1, 30'h0C10, 1, 30'h0C00, 0, 30'h0C11, 0, 4, 3); // stall not counted
        add(0, 30'h0C10, 1, 30'h0C10, 1, 30'h0C20, 0, 30'h0C11, 0, 5, 4); // ctr 01->10, retarget
        add(0, 30'h0C10, 0, 30'h0,    0, 30'h0,    0, 30'h0C20, 1, 6, 5); // new target
        add(0, 30'h0C0D, 1, 30'h0C50, 1, 30'h0D00, 0, 30'h0C0E, 0, 7, 5); // alias evicts
        add(0, 30'h0C10, 0, 30'h0,    0, 30'h0,    0, 30'h0C11, 0, 7, 6); // evicted: miss
        add(0, 30'h0C50, 0, 30'h0,    0, 30'h0,    0, 30'h0D00, 1, 7, 6); // new owner hits
        add(0, 30'h0C0D, 1, 30'h0C20, 0, 30'h0,    0, 30'h0C0E, 0, 8, 6); // miss NT: no change
        add(0, 30'h0C20, 0, 30'h0,    0, 30'h0,    0, 30'h0C21, 0, 8, 6);
        add(0, 30'h3FFFFFFF, 0, 30'h0, 0, 30'h0,   0, 30'h0,    0, 8, 6); // wrap to 0
        add(1, 30'h0C50, 1, 30'h0C60, 1, 30'h0C00, 0, 30'h0D00, 1, 8, 6); // rst + upd
        add(0, 30'h0C50, 0, 30'h0,    0, 30'h0,    0, 30'h0C51, 0, 0, 0); // all invalid
        add(0, 30'h0C60, 0, 30'h0,    0, 30'h0,    0, 30'h0C61, 0, 0, 0); // update dropped
        add(0, 30'h3FFFFFFF, 0, 30'h0, 0, 30'h0,   0, 30'h0,    0, 0, 0);
        add(0, 30'h0C0D, 1, 30'h0C50, 1, 30'h0D00, 0, 30'h0C0E, 0, 0, 0); // re-allocate
        add(0, 30'h0C50, 1, 30'h0C50, 1, 30'h0D00, 0, 30'h0D00, 1, 0, 1); // 10->11
        add(0, 30'h0C50, 1, 30'h0C50, 1, 30'h0D00, 0, 30'h0D00, 1, 1, 2); // 11 saturated
        add(0, 30'h0C50, 0, 30'h0,    0, 30'h0,    0, 30'h0D00, 1, 2, 2);

        rst = 1'b1; fetch_pc = 30'h0C0D; upd_valid = 1'b0; upd_pc = '0;
        upd_taken = 1'b0; upd_target = '0; stall = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

        // Allocation on the fetched index: miss this cycle, taken prediction the next.
        @(negedge clk);
        rst = 1'b0; fetch_pc = 30'h0C60; upd_valid = 1'b1; upd_pc = 30'h0C60;
        upd_taken = 1'b1; upd_target = 30'h0C04; stall = 1'b0;
        #2;
        check("alloc_same_cycle_pc",    100, 32'(predict_pc),    32'h0C61);
        check("alloc_same_cycle_taken", 100, 32'(predict_taken), 32'd0);
        @(negedge clk);
        upd_valid = 1'b0;
        #2;
        check("alloc_next_cycle_pc",    101, 32'(predict_pc),    32'h0C04);
        check("alloc_next_cycle_taken", 101, 32'(predict_taken), 32'd1);
        check("alloc_upd_cnt",          101, 32'(upd_cnt),       32'd3);
        check("alloc_hit_cnt",          101, 32'(hit_cnt),       32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
